crossing_referee: RTL and testbench

Game-core sequencer for the cat/dog/mouse river-crossing puzzle. It consumes debounced button levels and a 1 Hz tick, and maintains animal and canoe positions, move count, the BCD countdown and the win/lose verdict. It sits directly upstream of the dot-matrix, digital-tube, LED and beeper display stages. Its position codes, BCD digits and state code feed those stages unchanged.

---
 rtl/crossing_referee_if.sv | 33 +++
 rtl/crossing_referee.sv | 210 +++++++++++++++++++++
 tb/tb_crossing_referee.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/crossing_referee_if.sv
// Game I/O bundle between the referee core and its surroundings:
// debounced keys, tick and enable in; positions, timer and verdict out.
interface crossing_referee_if;
  logic       tick_1Hz;
  logic       en;
  logic       difficulty;
  logic       key_cat;
  logic       key_dog;
  logic       key_mouse;
  logic       key_canoe;
  logic [1:0] cnt_cat;
  logic [1:0] cnt_dog;
  logic [1:0] cnt_mouse;
  logic       canoe_side;
  logic       canoe_moving;
  logic [3:0] cnt_canoe;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] gameState;
  logic       evt;

  modport master (
    output tick_1Hz, en, difficulty, key_cat, key_dog, key_mouse, key_canoe,
    input  cnt_cat, cnt_dog, cnt_mouse, canoe_side, canoe_moving, cnt_canoe,
           ones, tens, gameState, evt
  );

  modport slave (
    input  tick_1Hz, en, difficulty, key_cat, key_dog, key_mouse, key_canoe,
    output cnt_cat, cnt_dog, cnt_mouse, canoe_side, canoe_moving, cnt_canoe,
           ones, tens, gameState, evt
  );
endinterface

// File: rtl/crossing_referee.sv
// River-crossing game referee: tracks cat/dog/mouse/canoe positions,
// departure count, BCD countdown and the win/lose verdict.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a rising edge on en, everything at rest
// S_PLAY  | canoe docked, animal keys board/unload, canoe key departs
// S_CROSS | canoe under way, next tick is arrival
// S_WIN   | all animals on the right bank, outputs frozen
// S_LOSE  | timeout, move limit or unsafe bank, outputs frozen
module crossing_referee #(
  parameter int TIME_EASY = 30,
  parameter int TIME_HARD = 20,
  parameter int MAX_MOVES = 15
) (
  input logic              clk_1kHz,
  input logic              btn_0,
  crossing_referee_if.slave io
);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CROSS, S_WIN, S_LOSE} state_t;

  localparam logic [1:0] POS_LEFT  = 2'b00;
  localparam logic [1:0] POS_BOAT  = 2'b01;
  localparam logic [1:0] POS_RIGHT = 2'b10;
  localparam logic [3:0] EASY_TENS = 4'(TIME_EASY / 10);
  localparam logic [3:0] EASY_ONES = 4'(TIME_EASY % 10);
  localparam logic [3:0] HARD_TENS = 4'(TIME_HARD / 10);
  localparam logic [3:0] HARD_ONES = 4'(TIME_HARD % 10);
  localparam logic [3:0] MOVE_CAP  = 4'(MAX_MOVES);

  state_t     state_q, state_d;
  logic [1:0] cat_q, cat_d, dog_q, dog_d, mouse_q, mouse_d;
  logic       side_q, side_d, moving_q, moving_d, evt_q, evt_d;
  logic [3:0] moves_q, moves_d, ones_q, ones_d, tens_q, tens_d;
  logic [3:0] key_prev_q, key_prev_d;
  logic       en_prev_q, en_prev_d;

  logic [3:0] keys, key_rise;
  logic       en_rise, canoe_empty, cat_here, dog_here, mouse_here;
  logic [1:0] bank;
  logic [3:0] dec_ones, dec_tens;
  logic       dec_zero;

  // Board from the canoe's bank into an empty canoe, or unload onto that bank.
  function automatic logic [1:0] animal_step(input logic [1:0] pos, input logic [1:0] at_bank,
                                              input logic empty);
    logic [1:0] nxt;
    nxt = pos;
    if (pos == POS_BOAT)             nxt = at_bank;
    else if (pos == at_bank && empty) nxt = POS_BOAT;
    return nxt;
  endfunction

  // Edge detection, bank occupancy and the decremented timer value.
  always_comb begin
    keys        = {io.key_canoe, io.key_mouse, io.key_dog, io.key_cat};
    key_rise    = keys & ~key_prev_q;
    en_rise     = io.en & ~en_prev_q;
    bank        = side_q ? POS_RIGHT : POS_LEFT;
    canoe_empty = (cat_q != POS_BOAT) && (dog_q != POS_BOAT) && (mouse_q != POS_BOAT);
    cat_here    = (cat_q == bank);
    dog_here    = (dog_q == bank);
    mouse_here  = (mouse_q == bank);
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end else begin
      dec_ones = ones_q - 4'd1;
      dec_tens = tens_q;
    end
    dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0);
  end

  // Game sequencing: next state and next value of every game register.
  always_comb begin
    state_d    = state_q;
    cat_d      = cat_q;
    dog_d      = dog_q;
    mouse_d    = mouse_q;
    side_d     = side_q;
    moving_d   = moving_q;
    moves_d    = moves_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    evt_d      = 1'b0;
    key_prev_d = keys;
    en_prev_d  = io.en;

    if (!io.en) begin
      state_d  = S_IDLE;
      cat_d    = POS_LEFT;
      dog_d    = POS_LEFT;
      mouse_d  = POS_LEFT;
      side_d   = 1'b0;
      moving_d = 1'b0;
      moves_d  = 4'd0;
      ones_d   = 4'd0;
      tens_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_rise) begin
            state_d = S_PLAY;
            tens_d  = io.difficulty ? HARD_TENS : EASY_TENS;
            ones_d  = io.difficulty ? HARD_ONES : EASY_ONES;
          end
        end
        S_PLAY: begin
          if (cat_q == POS_RIGHT && dog_q == POS_RIGHT && mouse_q == POS_RIGHT) begin
            state_d = S_WIN;
            evt_d   = 1'b1;
          end else begin
            if (io.tick_1Hz) begin
              ones_d = dec_ones;
              tens_d = dec_tens;
            end
            if (io.tick_1Hz && dec_zero) begin
              state_d = S_LOSE;
              evt_d   = 1'b1;
            end else if (key_rise[0]) begin
              cat_d = animal_step(cat_q, bank, canoe_empty);
            end else if (key_rise[1]) begin
              dog_d = animal_step(dog_q, bank, canoe_empty);
            end else if (key_rise[2]) begin
              mouse_d = animal_step(mouse_q, bank, canoe_empty);
            end else if (key_rise[3]) begin
              // The canoe occupant is coded 01, so it never counts as on the bank.
              if (moves_q == MOVE_CAP || (cat_here && mouse_here) || (dog_here && cat_here)) begin
                state_d = S_LOSE;
                evt_d   = 1'b1;
              end else begin
                moves_d  = moves_q + 4'd1;
                side_d   = ~side_q;
                moving_d = 1'b1;
                state_d  = S_CROSS;
              end
            end
          end
        end
        S_CROSS: begin
          if (io.tick_1Hz) begin
            ones_d = dec_ones;
            tens_d = dec_tens;
            if (dec_zero) begin
              state_d = S_LOSE;
              evt_d   = 1'b1;
            end else begin
              moving_d = 1'b0;
              state_d  = S_PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register update; reset preloads key history so held keys give no edge.
  always_ff @(posedge clk_1kHz) begin
    if (btn_0) begin
      state_q    <= S_IDLE;
      cat_q      <= POS_LEFT;
      dog_q      <= POS_LEFT;
      mouse_q    <= POS_LEFT;
      side_q     <= 1'b0;
      moving_q   <= 1'b0;
      moves_q    <= 4'd0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      evt_q      <= 1'b0;
      key_prev_q <= keys;
      en_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cat_q      <= cat_d;
      dog_q      <= dog_d;
      mouse_q    <= mouse_d;
      side_q     <= side_d;
      moving_q   <= moving_d;
      moves_q    <= moves_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      evt_q      <= evt_d;
      key_prev_q <= key_prev_d;
      en_prev_q  <= en_prev_d;
    end
  end

  // State code for the display stages, decoded from the registered state.
  always_comb begin
    case (state_q)
      S_WIN:           io.gameState = 2'd1;
      S_LOSE:          io.gameState = 2'd0;
      S_PLAY, S_CROSS: io.gameState = 2'd2;
      default:         io.gameState = 2'd3;
    endcase
  end

  assign io.cnt_cat      = cat_q;
  assign io.cnt_dog      = dog_q;
  assign io.cnt_mouse    = mouse_q;
  assign io.canoe_side   = side_q;
  assign io.canoe_moving = moving_q;
  assign io.cnt_canoe    = moves_q;
  assign io.ones         = ones_q;
  assign io.tens         = tens_q;
  assign io.evt          = evt_q;

endmodule

// File: tb/tb_crossing_referee.sv
// Directed bench for crossing_referee: a default instance plus a
// MAX_MOVES=2 instance sharing the same stimulus.
module tb_crossing_referee;

  logic clk;
  logic btn_0;
  int   n_tests;
  int   n_fail;

  crossing_referee_if ifa ();
  crossing_referee_if ifb ();

  crossing_referee #(.TIME_EASY(30), .TIME_HARD(20), .MAX_MOVES(15)) u_dut (
    .clk_1kHz(clk), .btn_0(btn_0), .io(ifa)
  );
  crossing_referee #(.TIME_EASY(30), .TIME_HARD(20), .MAX_MOVES(2)) u_dut_short (
    .clk_1kHz(clk), .btn_0(btn_0), .io(ifb)
  );

  assign ifb.tick_1Hz   = ifa.tick_1Hz;
  assign ifb.en         = ifa.en;
  assign ifb.difficulty = ifa.difficulty;
  assign ifb.key_cat    = ifa.key_cat;
  assign ifb.key_dog    = ifa.key_dog;
  assign ifb.key_mouse  = ifa.key_mouse;
  assign ifb.key_canoe  = ifa.key_canoe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: ifa.key_cat   = v;
      1: ifa.key_dog   = v;
      2: ifa.key_mouse = v;
      default: ifa.key_canoe = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1);
    cyc(1);
    set_key(k, 1'b0);
    cyc(1);
  endtask

  task automatic tick();
    ifa.tick_1Hz = 1'b1;
    cyc(1);
    ifa.tick_1Hz = 1'b0;
  endtask

  task automatic start_game(input logic d);
    ifa.en = 1'b0;
    cyc(1);
    ifa.difficulty = d;
    ifa.en = 1'b1;
    cyc(1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    btn_0 = 1'b1;
    ifa.tick_1Hz = 1'b0;
    ifa.en = 1'b1;
    ifa.difficulty = 1'b0;
    ifa.key_cat = 1'b1;
    ifa.key_dog = 1'b0;
    ifa.key_mouse = 1'b0;
    ifa.key_canoe = 1'b0;

    // Reset with key_cat and en held high.
    cyc(2);
    chk("rst_state", 8'(ifa.gameState), 8'd3);
    chk("rst_tens", 8'(ifa.tens), 8'd0);
    chk("rst_evt", 8'(ifa.evt), 8'd0);
    btn_0 = 1'b0;
    cyc(1);
    chk("rel_state", 8'(ifa.gameState), 8'd2);
    chk("rel_tens", 8'(ifa.tens), 8'd3);
    chk("rel_ones", 8'(ifa.ones), 8'd0);
    cyc(1);
    chk("held_cat", 8'(ifa.cnt_cat), 8'd0);
    ifa.key_cat = 1'b0;
    cyc(1);

    // Optimal 7-departure solution.
    start_game(1'b0);
    press(0); press(3);
    chk("opt_moving", 8'(ifa.canoe_moving), 8'd1);
    chk("opt_side", 8'(ifa.canoe_side), 8'd1);
    tick();
    cyc(1);
    chk("opt_arrive", 8'(ifa.canoe_moving), 8'd0);
    chk("opt_cat_boat", 8'(ifa.cnt_cat), 8'd1);
    press(0);
    chk("opt_cat_right", 8'(ifa.cnt_cat), 8'd2);
    press(3); tick();
    press(1); press(3); tick(); press(1);
    press(0); press(3); tick(); press(0);
    chk("opt_cat_back", 8'(ifa.cnt_cat), 8'd0);
    press(2); press(3); tick(); press(2);
    press(3); tick();
    press(0); press(3); tick(); press(0);
    chk("opt_win", 8'(ifa.gameState), 8'd1);
    chk("opt_evt", 8'(ifa.evt), 8'd1);
    chk("opt_moves", 8'(ifa.cnt_canoe), 8'd7);
    chk("opt_pos", 8'({ifa.cnt_cat, ifa.cnt_dog, ifa.cnt_mouse}), 8'b00_101010);
    chk("opt_tens", 8'(ifa.tens), 8'd2);
    chk("opt_ones", 8'(ifa.ones), 8'd3);
    cyc(1);
    chk("opt_evt_off", 8'(ifa.evt), 8'd0);
    tick();
    cyc(1);
    chk("opt_frozen", 8'(ifa.ones), 8'd3);
    chk("opt_still_win", 8'(ifa.gameState), 8'd1);

    // Dog boards first, departure leaves cat with mouse.
    start_game(1'b0);
    press(1);
    chk("dog_boat", 8'(ifa.cnt_dog), 8'd1);
    ifa.key_canoe = 1'b1;
    cyc(1);
    chk("unsafe_lose", 8'(ifa.gameState), 8'd0);
    chk("unsafe_evt", 8'(ifa.evt), 8'd1);
    chk("unsafe_moves", 8'(ifa.cnt_canoe), 8'd0);
    ifa.key_canoe = 1'b0;
    cyc(1);
    chk("unsafe_evt_off", 8'(ifa.evt), 8'd0);

    // Hard countdown to timeout, including the 10 -> 09 borrow.
    start_game(1'b1);
    chk("hard_tens", 8'(ifa.tens), 8'd2);
    chk("hard_ones", 8'(ifa.ones), 8'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("cd_tens_%0d", i), 8'(ifa.tens), 8'((20 - i) / 10));
      chk($sformatf("cd_ones_%0d", i), 8'(ifa.ones), 8'((20 - i) % 10));
      chk($sformatf("cd_state_%0d", i), 8'(ifa.gameState), (i < 20) ? 8'd2 : 8'd0);
      if (i == 20) chk("cd_evt", 8'(ifa.evt), 8'd1);
      cyc(1);
    end

    // Cat and mouse edges in the same cycle: cat wins, mouse dropped.
    start_game(1'b0);
    ifa.key_cat = 1'b1;
    ifa.key_mouse = 1'b1;
    cyc(1);
    ifa.key_cat = 1'b0;
    ifa.key_mouse = 1'b0;
    cyc(1);
    chk("simul_cat", 8'(ifa.cnt_cat), 8'd1);
    chk("simul_mouse", 8'(ifa.cnt_mouse), 8'd0);

    // Move limit on the MAX_MOVES=2 instance.
    start_game(1'b0);
    press(0); press(3); tick(); cyc(1);
    press(3); tick(); cyc(1);
    chk("cap_two_moves", 8'(ifb.cnt_canoe), 8'd2);
    ifa.key_canoe = 1'b1;
    cyc(1);
    chk("cap_lose", 8'(ifb.gameState), 8'd0);
    chk("cap_moves", 8'(ifb.cnt_canoe), 8'd2);
    chk("cap_evt", 8'(ifb.evt), 8'd1);
    chk("cap_wide_ok", 8'(ifa.cnt_canoe), 8'd3);
    ifa.key_canoe = 1'b0;
    cyc(1);

    // en dropped mid-crossing returns to idle values.
    start_game(1'b0);
    press(0); press(3);
    chk("mid_cross", 8'(ifa.canoe_moving), 8'd1);
    ifa.en = 1'b0;
    cyc(1);
    chk("mid_idle", 8'(ifa.gameState), 8'd3);
    chk("mid_moving", 8'(ifa.canoe_moving), 8'd0);
    chk("mid_moves", 8'(ifa.cnt_canoe), 8'd0);
    chk("mid_cat", 8'(ifa.cnt_cat), 8'd0);
    chk("mid_side", 8'(ifa.canoe_side), 8'd0);
    chk("mid_timer", 8'({ifa.tens, ifa.ones}), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
